// File: rtl/dpsk_diff_decoder.sv
// ---------------------------------------------------------------------------
// dpsk_diff_decoder
//
// Sits behind the DPSK/BPSK demodulator. Once per symbol it samples the
// demodulator's hard decision, differentially decodes it (current XOR
// previous), hunts for a sync byte and then deserialises a fixed-length
// frame of payload bytes MSB-first. Bytes are handed to the framing/UART
// stage over a valid/ready interface.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   dm_in        demodulator decision; all bits equal, only dm_in[7] is used
//   byte_ready   consumer accepts byte_out this cycle
//   byte_out     decoded payload byte
//   byte_valid   byte_out holds an unconsumed byte
//   frame_start  one-cycle pulse when the sync word has been detected
//   locked       high while payload bytes are being received
//   overflow     sticky flag: a completed byte was dropped under back-pressure
// ---------------------------------------------------------------------------
module dpsk_diff_decoder #(
   parameter int          SYM_LEN      = 128,
   parameter int          SAMPLE_PHASE = 33,
   parameter logic [7:0]  SYNC_WORD    = 8'hA5,
   parameter int          FRAME_BYTES  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] dm_in,
   input  logic       byte_ready,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       frame_start,
   output logic       locked,
   output logic       overflow
);

   localparam int CNT_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;

   typedef enum logic {
      HUNT = 1'b0,
      DATA = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  symCnt_q, symCnt_d;
   logic              prev_q, prev_d;
   logic [7:0]        window_q, window_d;
   logic [7:0]        shreg_q, shreg_d;
   logic [2:0]        bitCnt_q, bitCnt_d;
   logic [7:0]        byteCnt_q, byteCnt_d;
   logic [7:0]        byteOut_q, byteOut_d;
   logic              byteValid_q, byteValid_d;
   logic              frameStart_q, frameStart_d;
   logic              overflow_q, overflow_d;

   logic              strobe;
   logic              curBit;
   logic              decBit;
   logic [7:0]        windowNext;
   logic [7:0]        byteNext;
   logic              syncHit;
   logic              byteDone;
   logic              frameDone;

   // The demodulator drives the same decision on all eight bits; only the
   // MSB is needed, the rest are folded into a deliberately unused signal.
   logic              unusedDmBits;
   assign unusedDmBits = ^dm_in[6:0];

   // Symbol-timing and decode helpers. The sample strobe lands one count
   // after the demodulator refreshes its decision, so the sampled value is
   // always settled. The differential bit is formed against the decision
   // sampled on the previous strobe.
   always_comb begin
      strobe     = (symCnt_q == CNT_W'(SAMPLE_PHASE));
      curBit     = dm_in[7];
      decBit     = curBit ^ prev_q;
      windowNext = {window_q[6:0], decBit};
      byteNext   = {shreg_q[6:0], decBit};
      syncHit    = strobe && (state_q == HUNT) && (windowNext == SYNC_WORD);
      byteDone   = strobe && (state_q == DATA) && (bitCnt_q == 3'd7);
      frameDone  = byteDone && (byteCnt_q == 8'(FRAME_BYTES - 1));
   end

   // State register: the only place the FSM state is stored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. HUNT leaves as soon as the sliding window plus the
   // freshly decoded bit equals the sync word; DATA returns to HUNT once the
   // last payload byte of the frame has completed. Sync is deliberately not
   // searched for during DATA so payload cannot re-trigger a frame.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         HUNT: if (syncHit)   state_d = DATA;
         DATA: if (frameDone) state_d = HUNT;
         default:             state_d = HUNT;
      endcase
   end

   // Output logic of the FSM: locked simply mirrors DATA, which makes it
   // rise on the same edge that registers the frame_start pulse.
   always_comb begin
      locked = (state_q == DATA);
   end

   // Datapath next-state. Nothing moves between strobes except the symbol
   // counter and the output handshake. The output register gives priority to
   // a new byte when the consumer is taking the old one on the same edge;
   // only when the held byte is still unconsumed is the new byte dropped and
   // the sticky overflow raised.
   always_comb begin
      symCnt_d     = (symCnt_q == CNT_W'(SYM_LEN - 1)) ? '0 : symCnt_q + 1'b1;
      prev_d       = prev_q;
      window_d     = window_q;
      shreg_d      = shreg_q;
      bitCnt_d     = bitCnt_q;
      byteCnt_d    = byteCnt_q;
      byteOut_d    = byteOut_q;
      byteValid_d  = byteValid_q;
      frameStart_d = 1'b0;
      overflow_d   = overflow_q;

      if (strobe) begin
         prev_d = curBit;
         if (state_q == HUNT) begin
            window_d = windowNext;
            if (syncHit) begin
               bitCnt_d     = 3'd0;
               byteCnt_d    = 8'd0;
               frameStart_d = 1'b1;
            end
         end else begin
            shreg_d  = byteNext;
            bitCnt_d = bitCnt_q + 3'd1;
            if (byteDone) begin
               byteCnt_d = byteCnt_q + 8'd1;
            end
            if (frameDone) begin
               window_d = 8'd0;
            end
         end
      end

      if (byteValid_q && byte_ready) begin
         byteValid_d = 1'b0;
      end
      if (byteDone) begin
         if (!byteValid_q || byte_ready) begin
            byteOut_d   = byteNext;
            byteValid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   // Datapath registers, all cleared by the synchronous reset so that a
   // reset in the middle of a frame discards any pending byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         symCnt_q     <= '0;
         prev_q       <= 1'b0;
         window_q     <= 8'd0;
         shreg_q      <= 8'd0;
         bitCnt_q     <= 3'd0;
         byteCnt_q    <= 8'd0;
         byteOut_q    <= 8'd0;
         byteValid_q  <= 1'b0;
         frameStart_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         symCnt_q     <= symCnt_d;
         prev_q       <= prev_d;
         window_q     <= window_d;
         shreg_q      <= shreg_d;
         bitCnt_q     <= bitCnt_d;
         byteCnt_q    <= byteCnt_d;
         byteOut_q    <= byteOut_d;
         byteValid_q  <= byteValid_d;
         frameStart_q <= frameStart_d;
         overflow_q   <= overflow_d;
      end
   end

   assign byte_out    = byteOut_q;
   assign byte_valid  = byteValid_q;
   assign frame_start = frameStart_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_dpsk_diff_decoder.sv
// ---------------------------------------------------------------------------
// tb_dpsk_diff_decoder
//
// Self-checking bench for dpsk_diff_decoder. Stimulus is generated one
// symbol at a time from the decoded bit wanted, differentially encoding it
// onto dm_in. Expected payload bytes go into a queue when they are driven and
// are popped by a monitor whenever the DUT completes a handshake.
// ---------------------------------------------------------------------------
module tb_dpsk_diff_decoder;

   localparam int         SYM   = 128;
   localparam int         PHASE = 33;
   localparam logic [7:0] SYNC  = 8'hA5;

   logic       clk;
   logic       reset;
   logic [7:0] dm_in;
   logic       byte_ready;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       frame_start;
   logic       locked;
   logic       overflow;

   int         checks;
   int         errors;
   logic [7:0] expQ[$];
   logic       tbPrev;

   // Observations taken just after the sampling edge of the latest symbol.
   logic       obsFs;
   logic       obsValid;
   logic       obsLocked;
   logic       obsOvf;
   logic [7:0] obsByte;
   int         fsPulses;
   int         fsWrong;

   dpsk_diff_decoder #(
      .SYM_LEN      (SYM),
      .SAMPLE_PHASE (PHASE),
      .SYNC_WORD    (SYNC),
      .FRAME_BYTES  (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .dm_in       (dm_in),
      .byte_ready  (byte_ready),
      .byte_out    (byte_out),
      .byte_valid  (byte_valid),
      .frame_start (frame_start),
      .locked      (locked),
      .overflow    (overflow)
   );

   // Free-running 100 MHz-style clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Scoreboard monitor: looks a little after each falling edge, once the
   // stimulus for that half-cycle has settled, and pops the queue whenever a
   // handshake is about to happen on the next rising edge.
   always begin
      @(negedge clk);
      #2;
      if (!reset && byte_valid && byte_ready) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_unexpected: got byte %h, expected no byte", byte_out);
         end else begin
            logic [7:0] exp;
            exp = expQ.pop_front();
            if (byte_out !== exp) begin
               errors++;
               $display("[TB] FAIL scoreboard_byte: got %h, expected %h", byte_out, exp);
            end
         end
      end
   end

   // Reset for one edge, leaving the bench at the falling edge right after
   // it, where the DUT symbol counter reads 0.
   task automatic doReset();
      reset      = 1'b1;
      dm_in      = 8'h00;
      byte_ready = 1'b0;
      @(negedge clk);
      reset  = 1'b0;
      tbPrev = 1'b0;
      expQ.delete();
      fsPulses = 0;
      fsWrong  = 0;
   endtask

   // One symbol carrying decoded bit bitVal. rdyMode: 0 ready low,
   // 1 ready high, 2 ready high only during the sampling cycle.
   task automatic sendSym(input logic bitVal, input int rdyMode);
      logic cur;
      cur        = tbPrev ^ bitVal;
      tbPrev     = cur;
      dm_in      = {8{cur}};
      byte_ready = (rdyMode == 1);
      for (int i = 1; i <= SYM; i++) begin
         @(negedge clk);
         if (frame_start) begin
            fsPulses++;
            if (i != PHASE + 1) fsWrong++;
         end
         if (i == PHASE && rdyMode == 2) byte_ready = 1'b1;
         if (i == PHASE + 1) begin
            byte_ready = (rdyMode == 1);
            obsFs      = frame_start;
            obsValid   = byte_valid;
            obsLocked  = locked;
            obsOvf     = overflow;
            obsByte    = byte_out;
         end
      end
   endtask

   // Eight symbols, MSB first; the last symbol may use its own ready mode.
   task automatic sendByte(input logic [7:0] b, input int rdy, input int rdyLast);
      for (int k = 7; k >= 0; k--) begin
         sendSym(b[k], (k == 0) ? rdyLast : rdy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      doReset();
      checks++;
      if ({byte_out, byte_valid, frame_start, locked, overflow} !== 12'h000) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got out=%h v=%b fs=%b lk=%b ov=%b, expected all 0",
                  byte_out, byte_valid, frame_start, locked, overflow);
      end
   endtask

   // Single-cycle pulse of dm_in at symbol count pulsePhase of symbol 0,
   // followed by a tail that completes the sync word only if the pulse was
   // sampled (decoded bits 1,1,0 for symbols 0..2).
   task automatic test_sample_timing(input int pulsePhase, input logic expectLock);
      doReset();
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < SYM; i++) begin
            dm_in = (s == 0 && i == pulsePhase) ? 8'hFF : 8'h00;
            @(negedge clk);
         end
      end
      tbPrev = 1'b0;
      sendSym(1'b1, 0);
      sendSym(1'b0, 0);
      sendSym(1'b0, 0);
      sendSym(1'b1, 0);
      sendSym(1'b0, 0);
      sendSym(1'b1, 0);
      checks++;
      if (fsPulses !== (expectLock ? 1 : 0)) begin
         errors++;
         $display("[TB] FAIL sample_phase%0d_fs: got %0d pulses, expected %0d",
                  pulsePhase, fsPulses, expectLock ? 1 : 0);
      end
      checks++;
      if (locked !== expectLock) begin
         errors++;
         $display("[TB] FAIL sample_phase%0d_locked: got %b, expected %b", pulsePhase, locked, expectLock);
      end
   endtask

   task automatic test_lock_payload();
      logic [7:0] payload [4];
      payload = '{8'h3C, 8'h00, 8'hFF, 8'h81};
      doReset();
      sendByte(SYNC, 1, 1);
      checks++;
      if (obsFs !== 1'b1 || obsLocked !== 1'b1) begin
         errors++;
         $display("[TB] FAIL lock_frame_start: got fs=%b lk=%b, expected 1 1", obsFs, obsLocked);
      end
      for (int n = 0; n < 4; n++) begin
         expQ.push_back(payload[n]);
         sendByte(payload[n], 1, 1);
         checks++;
         if (obsValid !== 1'b1 || obsByte !== payload[n]) begin
            errors++;
            $display("[TB] FAIL lock_byte%0d: got v=%b %h, expected v=1 %h", n, obsValid, obsByte, payload[n]);
         end
      end
      checks++;
      if (obsLocked !== 1'b0) begin
         errors++;
         $display("[TB] FAIL lock_release: got locked=%b, expected 0", obsLocked);
      end
      checks++;
      if (fsPulses !== 1 || fsWrong !== 0) begin
         errors++;
         $display("[TB] FAIL lock_fs_count: got %0d pulses (%0d mistimed), expected 1 (0)", fsPulses, fsWrong);
      end
      checks++;
      if (expQ.size() !== 0) begin
         errors++;
         $display("[TB] FAIL lock_undelivered: got %0d bytes left, expected 0", expQ.size());
      end
   endtask

   task automatic test_no_lock();
      int fsHigh;
      int lkHigh;
      int vHigh;
      fsHigh = 0;
      lkHigh = 0;
      vHigh  = 0;
      doReset();
      dm_in = 8'hFF;
      for (int i = 0; i < 200 * SYM; i++) begin
         @(negedge clk);
         if (frame_start) fsHigh++;
         if (locked)      lkHigh++;
         if (byte_valid)  vHigh++;
      end
      checks++;
      if (fsHigh !== 0 || lkHigh !== 0 || vHigh !== 0) begin
         errors++;
         $display("[TB] FAIL no_lock: got fs=%0d lk=%0d v=%0d high cycles, expected 0 0 0", fsHigh, lkHigh, vHigh);
      end
   endtask

   task automatic test_back_pressure();
      doReset();
      sendByte(SYNC, 0, 0);
      expQ.push_back(8'h3C);
      sendByte(8'h3C, 0, 0);
      checks++;
      if (obsValid !== 1'b1 || obsByte !== 8'h3C || obsOvf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_first: got v=%b %h ov=%b, expected v=1 3c ov=0", obsValid, obsByte, obsOvf);
      end
      sendByte(8'h00, 0, 0);
      checks++;
      if (obsValid !== 1'b1 || obsByte !== 8'h3C || obsOvf !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_overflow: got v=%b %h ov=%b, expected v=1 3c ov=1", obsValid, obsByte, obsOvf);
      end
      sendByte(8'hFF, 0, 0);
      sendByte(8'h81, 0, 0);
      checks++;
      if (byte_out !== 8'h3C || byte_valid !== 1'b1 || locked !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_hold: got %h v=%b lk=%b, expected 3c v=1 lk=0", byte_out, byte_valid, locked);
      end
      byte_ready = 1'b1;
      @(negedge clk);
      byte_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (byte_valid !== 1'b0 || overflow !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_drain: got v=%b ov=%b, expected v=0 ov=1", byte_valid, overflow);
      end
      checks++;
      if (expQ.size() !== 0) begin
         errors++;
         $display("[TB] FAIL bp_undelivered: got %0d bytes left, expected 0", expQ.size());
      end
   endtask

   task automatic test_simultaneous();
      doReset();
      sendByte(SYNC, 0, 0);
      expQ.push_back(8'h3C);
      sendByte(8'h3C, 0, 0);
      expQ.push_back(8'h00);
      sendByte(8'h00, 0, 2);
      checks++;
      if (obsByte !== 8'h00 || obsValid !== 1'b1 || obsOvf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL simul_load: got %h v=%b ov=%b, expected 00 v=1 ov=0", obsByte, obsValid, obsOvf);
      end
      expQ.push_back(8'hFF);
      sendByte(8'hFF, 1, 1);
      expQ.push_back(8'h81);
      sendByte(8'h81, 1, 1);
      checks++;
      if (overflow !== 1'b0 || expQ.size() !== 0) begin
         errors++;
         $display("[TB] FAIL simul_end: got ov=%b left=%0d, expected ov=0 left=0", overflow, expQ.size());
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] payload [4];
      payload = '{8'h5A, 8'hC3, 8'h01, 8'h80};
      doReset();
      sendByte(SYNC, 0, 0);
      expQ.push_back(8'h3C);
      sendByte(8'h3C, 0, 0);
      for (int k = 0; k < 3; k++) sendSym(1'b0, 0);
      checks++;
      if (locked !== 1'b1 || byte_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_pre: got lk=%b v=%b, expected 1 1", locked, byte_valid);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({byte_out, byte_valid, frame_start, locked, overflow} !== 12'h000) begin
         errors++;
         $display("[TB] FAIL midreset_clear: got out=%h v=%b fs=%b lk=%b ov=%b, expected all 0",
                  byte_out, byte_valid, frame_start, locked, overflow);
      end
      reset  = 1'b0;
      tbPrev = 1'b0;
      expQ.delete();
      fsPulses = 0;
      sendByte(SYNC, 1, 1);
      checks++;
      if (obsFs !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_resync: got fs=%b, expected 1", obsFs);
      end
      for (int n = 0; n < 4; n++) begin
         expQ.push_back(payload[n]);
         sendByte(payload[n], 1, 1);
         checks++;
         if (obsValid !== 1'b1 || obsByte !== payload[n]) begin
            errors++;
            $display("[TB] FAIL midreset_byte%0d: got v=%b %h, expected v=1 %h", n, obsValid, obsByte, payload[n]);
         end
      end
      checks++;
      if (locked !== 1'b0 || expQ.size() !== 0) begin
         errors++;
         $display("[TB] FAIL midreset_end: got lk=%b left=%0d, expected 0 0", locked, expQ.size());
      end
   endtask

   // Test sequence.
   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      dm_in      = 8'h00;
      byte_ready = 1'b0;
      tbPrev     = 1'b0;
      fsPulses   = 0;
      fsWrong    = 0;
      obsFs      = 1'b0;
      obsValid   = 1'b0;
      obsLocked  = 1'b0;
      obsOvf     = 1'b0;
      obsByte    = 8'h00;

      test_reset();
      $display("[TB] sample timing");
      test_sample_timing(PHASE, 1'b1);
      test_sample_timing(PHASE + 1, 1'b0);
      $display("[TB] lock and payload");
      test_lock_payload();
      $display("[TB] no lock");
      test_no_lock();
      $display("[TB] back-pressure");
      test_back_pressure();
      $display("[TB] simultaneous load and handshake");
      test_simultaneous();
      $display("[TB] mid-frame reset");
      test_mid_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
